// File: rtl/decode_pkg.sv
// Shared constants and types for the instruction-decode stage.
package decode_pkg;

  // Opcode class boundaries for instr[37:34]
  localparam logic [3:0] OP_R_LAST = 4'h7;
  localparam logic [3:0] OP_I_LAST = 4'hB;
  localparam logic [3:0] OP_M_LAST = 4'hD;
  localparam logic [3:0] OP_SHIFT  = 4'hE;
  localparam logic [3:0] OP_LIW    = 4'hF;

  // Field bit positions inside the instruction word
  localparam int unsigned OPC_HI = 37;
  localparam int unsigned OPC_LO = 34;
  localparam int unsigned RD_HI  = 33;
  localparam int unsigned RD_LO  = 29;
  localparam int unsigned RS1_HI = 28;
  localparam int unsigned RS1_LO = 24;
  localparam int unsigned RS2_HI = 23;
  localparam int unsigned RS2_LO = 19;

  // Immediate format selector
  typedef enum logic [1:0] {
    IMM_10   = 2'b00,
    IMM_16   = 2'b01,
    IMM_2    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  // FSM states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXT  = 1'b1;

  // LIW classifies as IMM_NONE; its immediate comes from the concatenation path.
  function automatic imm_src_e classify(input logic [3:0] opcode);
    if (opcode <= OP_R_LAST) begin
      return IMM_NONE;
    end else if (opcode <= OP_I_LAST) begin
      return IMM_10;
    end else if (opcode <= OP_M_LAST) begin
      return IMM_16;
    end else if (opcode == OP_SHIFT) begin
      return IMM_2;
    end
    return IMM_NONE;
  endfunction

endpackage

// File: rtl/decode_ctrl_sign_extend.sv
// Combinational immediate sign extension driven by the classified format.
module decode_ctrl_sign_extend
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic [15:0]       imm_bits,
  input  imm_src_e          imm_src,
  output logic [DATA_W-1:0] imm
);

  // Select and sign-extend the immediate field for the given format
  always_comb begin
    imm = '0;
    case (imm_src)
      IMM_10:  imm = {{(DATA_W - 10){imm_bits[9]}}, imm_bits[9:0]};
      IMM_16:  imm = {{(DATA_W - 16){imm_bits[15]}}, imm_bits[15:0]};
      IMM_2:   imm = {{(DATA_W - 2){imm_bits[1]}}, imm_bits[1:0]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Registered decode stage: classifies opcodes, extends immediates and
// assembles the two-beat LIW instruction behind a valid/ready handshake.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 38,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned REG_W   = 5,
  parameter logic [3:0]  LIW_OP  = OP_LIW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [1:0]         out_imm_src,
  output logic [DATA_W-1:0]  out_imm
);

  logic [0:0]        state_q, state_d;
  logic [3:0]        hold_op_q;
  logic [REG_W-1:0]  hold_rd_q, hold_rs1_q, hold_rs2_q;
  logic [15:0]       hold_imm_q;

  logic [3:0]        in_op;
  logic [REG_W-1:0]  in_rd, in_rs1, in_rs2;
  logic              accept, is_liw, load, capture;
  imm_src_e          dec_src;
  logic [DATA_W-1:0] se_imm;

  logic [3:0]        ld_op;
  logic [REG_W-1:0]  ld_rd, ld_rs1, ld_rs2;
  logic [1:0]        ld_src;
  logic [DATA_W-1:0] ld_imm;

  // Bits [18:16] carry no decoded field
  logic unused_bits;
  assign unused_bits = ^in_instr[18:16];

  assign in_op  = in_instr[OPC_HI:OPC_LO];
  assign in_rd  = in_instr[RD_HI:RD_LO];
  assign in_rs1 = in_instr[RS1_HI:RS1_LO];
  assign in_rs2 = in_instr[RS2_HI:RS2_LO];

  assign in_ready = ~rst & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_liw   = (in_op == LIW_OP);
  // In S_EXT any accepted beat is word 2, whatever its opcode field says
  assign load     = accept & ((state_q == S_EXT) | ~is_liw);
  assign capture  = accept & (state_q == S_IDLE) & is_liw;
  assign dec_src  = classify(in_op);

  decode_ctrl_sign_extend #(
    .DATA_W (DATA_W)
  ) u_sign_extend (
    .imm_bits (in_instr[15:0]),
    .imm_src  (dec_src),
    .imm      (se_imm)
  );

  // Choose the bundle to load: held LIW fields in S_EXT, fresh decode otherwise
  always_comb begin
    ld_op  = in_op;
    ld_rd  = in_rd;
    ld_rs1 = in_rs1;
    ld_rs2 = in_rs2;
    ld_src = dec_src;
    ld_imm = se_imm;
    if (state_q == S_EXT) begin
      ld_op  = hold_op_q;
      ld_rd  = hold_rd_q;
      ld_rs1 = hold_rs1_q;
      ld_rs2 = hold_rs2_q;
      ld_src = IMM_NONE;
      ld_imm = {in_instr[7:0], hold_imm_q};
    end
  end

  // Next-state logic for LIW sequencing
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      if (state_q == S_IDLE) begin
        state_d = is_liw ? S_EXT : S_IDLE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register for LIW word 1
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_op_q  <= '0;
      hold_rd_q  <= '0;
      hold_rs1_q <= '0;
      hold_rs2_q <= '0;
      hold_imm_q <= '0;
    end else if (capture) begin
      hold_op_q  <= in_op;
      hold_rd_q  <= in_rd;
      hold_rs1_q <= in_rs1;
      hold_rs2_q <= in_rs2;
      hold_imm_q <= in_instr[15:0];
    end
  end

  // Output register: load, drain, or hold under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm_src <= '0;
      out_imm     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_opcode  <= ld_op;
      out_rd      <= ld_rd;
      out_rs1     <= ld_rs1;
      out_rs2     <= ld_rs2;
      out_imm_src <= ld_src;
      out_imm     <= ld_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [37:0] in_instr;
  logic        in_ready, out_valid;
  logic [3:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  out_imm_src;
  logic [23:0] out_imm;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm_src (out_imm_src),
    .out_imm     (out_imm)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the bundle execute should currently see, plus pending LIW word 1
  bit          m_valid;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [1:0]  m_src;
  logic [23:0] m_imm;
  bit          m_pend;
  logic [37:0] m_w1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [37:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [15:0] low);
    return {op, rd, rs1, rs2, 3'b101, low};
  endfunction

  // Two's-complement reinterpretation of an unsigned field of the given width
  function automatic int to_signed(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  task automatic model_decode(input logic [37:0] w);
    int op;
    int s;
    op    = int'(w[37:34]);
    m_op  = w[37:34];
    m_rd  = w[33:29];
    m_rs1 = w[28:24];
    m_rs2 = w[23:19];
    s     = 0;
    if (op < 8) begin
      m_src = 2'd3;
    end else if (op < 12) begin
      m_src = 2'd0;
      s = to_signed(int'(w[9:0]), 10);
    end else if (op < 14) begin
      m_src = 2'd1;
      s = to_signed(int'(w[15:0]), 16);
    end else begin
      m_src = 2'd2;
      s = to_signed(int'(w[1:0]), 2);
    end
    m_imm = s[23:0];
  endtask

  // One clock: drive inputs, check DUT against model, advance the model
  task automatic step(input bit r, input bit f, input bit v, input logic [37:0] w,
                      input bit ordy);
    bit exp_rdy;
    bit acc;
    int liw_imm;
    rst = r; flush = f; in_valid = v; in_instr = w; out_ready = ordy;
    #1;
    exp_rdy = !r && !f && (!m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_opcode", out_opcode, m_op);
      check("out_rd", out_rd, m_rd);
      check("out_rs1", out_rs1, m_rs1);
      check("out_rs2", out_rs2, m_rs2);
      check("out_imm_src", out_imm_src, m_src);
      check("out_imm", out_imm, m_imm);
    end
    acc = v && exp_rdy;
    if (r) begin
      m_valid = 0; m_pend = 0;
      m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_src = '0; m_imm = '0;
    end else if (f) begin
      m_valid = 0; m_pend = 0;
    end else if (acc && m_pend) begin
      m_op  = m_w1[37:34];
      m_rd  = m_w1[33:29];
      m_rs1 = m_w1[28:24];
      m_rs2 = m_w1[23:19];
      m_src = 2'd3;
      liw_imm = int'(w[7:0]) * 65536 + int'(m_w1[15:0]);
      m_imm = liw_imm[23:0];
      m_valid = 1; m_pend = 0;
    end else if (acc && w[37:34] == 4'hF) begin
      m_pend = 1; m_w1 = w;
      m_valid = 0;  // any old bundle drains since acceptance needed ready
    end else if (acc) begin
      model_decode(w);
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [37:0] w;
    rst = 1; flush = 0; in_valid = 0; in_instr = '0; out_ready = 0;
    m_valid = 0; m_pend = 0; m_w1 = '0;
    m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_src = '0; m_imm = '0;
    @(posedge clk);
    #1;

    // Reset
    step(1, 0, 1, mk(4'h8, 5'd1, 5'd1, 5'd1, 16'h0001), 1);
    step(1, 0, 0, '0, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_opcode", out_opcode, 0);
    check("rst_out_imm_src", out_imm_src, 0);

    // I-type all-ones immediate
    step(0, 0, 1, mk(4'h8, 5'd1, 5'd2, 5'd3, 16'h03FF), 1);
    check("itype_valid", out_valid, 1);
    check("itype_src", out_imm_src, 2'b00);
    check("itype_imm", out_imm, 24'hFFFFFF);

    // M-type then shift back-to-back
    step(0, 0, 1, mk(4'hC, 5'd4, 5'd5, 5'd6, 16'h7FFF), 1);
    check("mtype_imm", out_imm, 24'h007FFF);
    step(0, 0, 1, mk(4'hE, 5'd7, 5'd8, 5'd9, 16'hFFFE), 1);
    check("shift_imm", out_imm, 24'hFFFFFE);
    check("shift_src", out_imm_src, 2'b10);

    // LIW with three bubbles between words
    step(0, 0, 1, mk(4'hF, 5'd11, 5'd12, 5'd13, 16'hBEEF), 1);
    check("liw_w1_no_bundle", out_valid, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, mk(4'h3, 5'd0, 5'd0, 5'd0, 16'hAA12), 0);
    check("liw_imm", out_imm, 24'h12BEEF);
    check("liw_src", out_imm_src, 2'b11);
    check("liw_rd", out_rd, 5'd11);

    // Stall for four cycles, then release
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, mk(4'h2, 5'd20, 5'd21, 5'd22, 16'h1234), 0);
      check("stall_frozen_imm", out_imm, 24'h12BEEF);
    end
    step(0, 0, 1, mk(4'h2, 5'd20, 5'd21, 5'd22, 16'h1234), 1);
    check("release_opcode", out_opcode, 4'h2);
    check("release_rd", out_rd, 5'd20);

    // Flush while in S_EXT
    step(0, 0, 1, mk(4'hF, 5'd3, 5'd3, 5'd3, 16'h5555), 1);
    step(0, 1, 1, mk(4'h9, 5'd1, 5'd1, 5'd1, 16'h0001), 1);
    check("flush_valid", out_valid, 0);
    step(0, 0, 1, mk(4'h1, 5'd9, 5'd10, 5'd11, 16'hFFFF), 1);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_src", out_imm_src, 2'b11);
    check("post_flush_imm", out_imm, 24'h0);

    // Reset in the middle of a stall
    step(0, 0, 1, mk(4'h9, 5'd17, 5'd18, 5'd19, 16'h0100), 0);
    step(0, 0, 1, mk(4'hF, 5'd2, 5'd2, 5'd2, 16'h0001), 0);
    step(1, 0, 1, mk(4'hF, 5'd2, 5'd2, 5'd2, 16'h0001), 0);
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_rd", out_rd, 0);
    check("rst_stall_imm", out_imm, 0);
    step(0, 0, 1, mk(4'hA, 5'd6, 5'd6, 5'd6, 16'h0200), 1);
    check("after_rst_imm", out_imm, 24'hFFFE00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      w = 38'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) w[37:34] = 4'hF;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Registered instruction-decode stage sitting between fetch and execute. Each cycle it accepts one 38-bit instruction word, classifies the opcode and selects the immediate format (ImmSrc). It sign-extends the immediate to 24 bits and presents a decoded bundle through a valid/ready handshake. It also sequences the two-word LIW (load-immediate-wide) instruction, which assembles a full 24-bit immediate from two consecutive fetch beats. It supports stall (back-pressure) and flush from the hazard unit.

## Interface
- INSTR_W, 38, instruction word width (fixed by ISA; not to be overridden)
- DATA_W, 24, datapath/immediate width
- REG_W, 5, register index width
- LIW_OP, 4'hF, opcode of the two-word load-immediate-wide instruction
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard the output register and any half-assembled LIW
- in_valid  input  1  fetch presents in_instr
- in_ready  output  1  decode can accept a beat this cycle
- in_instr  input  INSTR_W  raw instruction word
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts the bundle
- out_opcode  output  4  instr[37:34]
- out_rd, out_rs1, out_rs2  output  REG_W each  instr[33:29], [28:24], [23:19]
- out_imm_src  output  2  format selected: 00=10b, 01=16b, 10=2b, 11=none/LIW
- out_imm  output  DATA_W  extended immediate

## Operation
- Opcode map for instr[37:34]:
  - 0x0–0x7: R-type, imm_src=11, imm=0
  - 0x8–0xB: I-type, imm_src=00, sext(instr[9:0])
  - 0xC–0xD: M-type, imm_src=01, sext(instr[15:0])
  - 0xE: shift, imm_src=10, sext(instr[1:0])
  - 0xF: LIW
- Any other imm_src value yields imm=0.
- FSM states:
  - S_IDLE:
    - Accepted non-LIW beat → output register loads the decoded bundle; stay in S_IDLE.
    - Accepted LIW beat → hold register captures opcode/rd/rs1/rs2 and instr[15:0]; go to S_EXT. Output register unchanged.
  - S_EXT:
    - The next accepted beat is LIW word 2, regardless of its opcode.
    - Output loads the held fields, out_imm={beat2[7:0], held[15:0]} (no extension), imm_src=11.
    - Return to S_IDLE.
- Accept condition: in_valid & in_ready.
  - in_ready = ~rst & ~flush & (~out_valid | out_ready), identical in both states.
- Output register:
  - Set out_valid on load.
  - Clear out_valid when out_ready & ~load.
  - Hold all fields while out_valid & ~out_ready.
- Simultaneous drain and load (out_valid & out_ready & accept): new bundle replaces old; out_valid stays 1.
- flush: next cycle out_valid=0 and FSM=S_IDLE; the hold register is don't-care. The beat offered in the flush cycle is not accepted (in_ready=0).
- rst has priority over flush.

## Timing
- Reset values: out_valid=0, all out_* data=0, FSM=S_IDLE, hold register=0; in_ready=0 while rst=1.
- Latency:
  - Single-word instruction: accepted at cycle N → out_valid at N+1.
  - LIW: bundle at cycle after word 2 is accepted. Bubbles between words are allowed (FSM waits in S_EXT indefinitely).
- Throughput: one bundle per cycle with out_ready held high; LIW takes 2 accepted beats per bundle.
- Stall: out_ready low with out_valid high → in_ready low; fields stable cycle-to-cycle.
- Reset or flush while in S_EXT abandons word 1; the next beat is decoded as a fresh instruction.

## Structure
- Shared package decode_pkg holds:
  - opcode localparams and the class ranges
  - imm_src enum (IMM_10, IMM_16, IMM_2, IMM_NONE)
  - FSM state enum
  - bit-position constants for the opcode/rd/rs1/rs2 fields
- Sub-module: instantiate the existing Sign_Extend combinationally on in_instr with the classified imm_src. The LIW concatenation path bypasses it.
- Remaining logic is one FSM, one hold register and one output register.

## Test plan
- After reset, in_instr={4'h8,…,imm[9:0]=10'h3FF} → next cycle out_valid=1, imm_src=00, out_imm=24'hFFFFFF.
- M-type with instr[15:0]=16'h7FFF, then shift with instr[1:0]=2'b10, back-to-back, out_ready=1 → out_imm 24'h007FFF then 24'hFFFFFE, one per cycle.
- LIW word1 instr[15:0]=16'hBEEF, 3 idle cycles, word2 instr[7:0]=8'h12 → single bundle out_imm=24'h12BEEF, imm_src=11, rd from word1.
- out_ready=0 for 4 cycles with out_valid=1 → in_ready=0, outputs frozen. Release → the pending input is accepted the same cycle the old bundle drains.
- flush asserted in S_EXT → out_valid=0 next cycle. The following R-type beat decodes normally, with imm=0 and imm_src=11.
- rst asserted mid-stall → all outputs 0 next cycle, in_ready=0 during reset, FSM in S_IDLE afterwards.
